mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/rr_pick2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port identifiers and the stall-counter ceiling.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_LD  = 1'b1
  } port_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_pick2.sv
// Two-requester tie-break: round-robin against the last grant, except that a
// locked loader that won last time keeps the port.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic  req_cpu,
  input  logic  req_ld,
  input  port_t last,
  input  logic  lock,
  output port_t winner
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    winner = PORT_CPU;
    if (req_cpu && req_ld) begin
      if (lock && (last == PORT_LD)) winner = PORT_LD;
      else                           winner = (last == PORT_CPU) ? PORT_LD : PORT_CPU;
    end else if (req_ld) begin
      winner = PORT_LD;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a CPU port and a loader port onto one single-cycle memory port.
// Each transfer takes IDLE -> ACC -> DONE; the winner is acked in DONE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CpuReq,
  input  logic          CpuWr,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic          CpuAck,
  output logic          CpuStall,
  input  logic          LdReq,
  input  logic          LdWr,
  input  logic [AW-1:0] LdAddr,
  input  logic [DW-1:0] LdWData,
  input  logic          LdLock,
  output logic          LdAck,
  output logic [DW-1:0] RdData,
  output logic          MemRd,
  output logic          MemWr,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  output logic [15:0]   StallCnt
);

  state_t          state, state_nxt;
  port_t           last, lat_port, winner;
  logic            lat_wr;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic [DW-1:0]   rd_q;
  logic [15:0]     stall_q;

  rr_pick2 u_pick (
    .req_cpu (CpuReq),
    .req_ld  (LdReq),
    .last    (last),
    .lock    (LdLock),
    .winner  (winner)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= PORT_LD;
      lat_port  <= PORT_CPU;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_q      <= '0;
      stall_q   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (CpuReq || LdReq)) begin
        lat_port  <= winner;
        lat_wr    <= (winner == PORT_LD) ? LdWr    : CpuWr;
        lat_addr  <= (winner == PORT_LD) ? LdAddr  : CpuAddr;
        lat_wdata <= (winner == PORT_LD) ? LdWData : CpuWData;
      end
      if (state == DONE) begin
        last <= lat_port;
        if (!lat_wr) rd_q <= MemRData;
      end
      if (CpuStall && (stall_q != STALL_MAX)) stall_q <= stall_q + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    CpuAck    = 1'b0;
    LdAck     = 1'b0;
    case (state)
      IDLE: if (CpuReq || LdReq) state_nxt = ACC;
      ACC: begin
        MemRd     = ~lat_wr;
        MemWr     = lat_wr;
        state_nxt = DONE;
      end
      DONE: begin
        CpuAck    = (lat_port == PORT_CPU);
        LdAck     = (lat_port == PORT_LD);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data comes straight from memory in the ack cycle and is held afterwards.
  assign RdData   = ((state == DONE) && !lat_wr) ? MemRData : rd_q;
  assign MemAddr  = lat_addr & {{(AW-2){1'b1}}, 2'b00};
  assign MemWData = lat_wdata;
  assign CpuStall = CpuReq & ~CpuAck;
  assign StallCnt = stall_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a vector table
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CpuReq = 0, CpuWr = 0, LdReq = 0, LdWr = 0, LdLock = 0;
  logic [31:0] CpuAddr = 0, CpuWData = 0, LdAddr = 0, LdWData = 0;
  logic        CpuAck, CpuStall, LdAck, MemRd, MemWr;
  logic [31:0] RdData, MemAddr, MemWData;
  logic [31:0] MemRData;
  logic [15:0] StallCnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .CpuReq(CpuReq), .CpuWr(CpuWr), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuAck(CpuAck), .CpuStall(CpuStall),
    .LdReq(LdReq), .LdWr(LdWr), .LdAddr(LdAddr), .LdWData(LdWData),
    .LdLock(LdLock), .LdAck(LdAck), .RdData(RdData),
    .MemRd(MemRd), .MemWr(MemWr), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after MemRd.
  logic [31:0] mem [256];
  logic        bd_we = 0;
  logic [7:0]  bd_idx = 0;
  logic [31:0] bd_data = 0;
  logic [31:0] mem_rdata = 0;
  assign MemRData = mem_rdata;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (MemWr) mem[MemAddr[9:2]] <= MemWData;
    if (MemRd) mem_rdata <= mem[MemAddr[9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drop_all();
    CpuReq = 0; CpuWr = 0; LdReq = 0; LdWr = 0; LdLock = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    drop_all();
    tick();
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic        cpu_req; logic cpu_wr; logic [31:0] cpu_addr; logic [31:0] cpu_wdata;
    logic        ld_req;  logic ld_wr;  logic [31:0] ld_addr;  logic [31:0] ld_wdata;
    logic        lock;
    logic        exp_ld;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  // Reference model state for the randomized run.
  logic [31:0] mmem [32];
  int          next_sample, ack_cyc;
  logic        ack_ld, model_last, cpu_pend, ld_pend, w, wr_sel, hit;
  logic [31:0] exp_rd, model_rd, a_sel, d_sel;
  logic [15:0] exp_cnt;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 32'h0,   32'h0,        1, 1, 32'h40, 32'h12345678, 0, 1, 32'hDEADBEEF};
    vecs[1] = '{1, 0, 32'h40,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 32'h12345678};
    vecs[2] = '{1, 0, 32'h44,  32'h0,        1, 1, 32'h44, 32'hAAAA5555, 0, 1, 32'h12345678};
    vecs[3] = '{1, 0, 32'h44,  32'h0,        1, 0, 32'h44, 32'h0,        1, 1, 32'hAAAA5555};
    vecs[4] = '{1, 1, 32'h48,  32'h0BADF00D, 1, 0, 32'h48, 32'h0,        0, 0, 32'hAAAA5555};
    vecs[5] = '{1, 0, 32'h48,  32'h0,        1, 0, 32'h48, 32'h0,        1, 1, 32'h0BADF00D};
    vecs[6] = '{1, 0, 32'h103, 32'h0,        0, 0, 32'h0,  32'h0,        1, 0, 32'hDEADBEEF};
    vecs[7] = '{0, 0, 32'h0,   32'h0,        1, 0, 32'h4B, 32'h0,        0, 1, 32'h0BADF00D};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bd_we = 1; bd_idx = 8'd64; bd_data = 32'hDEADBEEF;
    rst = 1;
    drop_all();
    tick();
    bd_we = 0;
    do_reset();

    // Reset state, then a lone CPU read of 0x103.
    settle();
    check("rst_memrd", MemRd, 0);
    check("rst_memwr", MemWr, 0);
    check("rst_cpuack", CpuAck, 0);
    check("rst_ldack", LdAck, 0);
    check("rst_stallcnt", StallCnt, 0);
    check("rst_rddata", RdData, 0);
    CpuReq = 1; CpuWr = 0; CpuAddr = 32'h103;
    settle();
    check("rd_c1_stall", CpuStall, 1);
    check("rd_c1_memrd", MemRd, 0);
    tick(); settle();
    check("rd_c2_memrd", MemRd, 1);
    check("rd_c2_memwr", MemWr, 0);
    check("rd_c2_addr", MemAddr, 32'h100);
    check("rd_c2_stall", CpuStall, 1);
    check("rd_c2_ack", CpuAck, 0);
    tick(); settle();
    check("rd_c3_ack", CpuAck, 1);
    check("rd_c3_ldack", LdAck, 0);
    check("rd_c3_data", RdData, 32'hDEADBEEF);
    check("rd_c3_stall", CpuStall, 0);
    check("rd_c3_memrd", MemRd, 0);
    tick();
    CpuReq = 0;
    settle();
    check("rd_stallcnt", StallCnt, 2);

    // Vector table: one transaction per record, started from IDLE.
    for (int i = 0; i < 8; i++) begin
      CpuReq = vecs[i].cpu_req; CpuWr = vecs[i].cpu_wr;
      CpuAddr = vecs[i].cpu_addr; CpuWData = vecs[i].cpu_wdata;
      LdReq = vecs[i].ld_req; LdWr = vecs[i].ld_wr;
      LdAddr = vecs[i].ld_addr; LdWData = vecs[i].ld_wdata;
      LdLock = vecs[i].lock;
      wr_sel = vecs[i].exp_ld ? vecs[i].ld_wr : vecs[i].cpu_wr;
      a_sel  = vecs[i].exp_ld ? vecs[i].ld_addr : vecs[i].cpu_addr;
      d_sel  = vecs[i].exp_ld ? vecs[i].ld_wdata : vecs[i].cpu_wdata;
      settle();
      tick(); settle();
      check($sformatf("vec%0d_memrd", i), MemRd, !wr_sel);
      check($sformatf("vec%0d_memwr", i), MemWr, wr_sel);
      check($sformatf("vec%0d_addr", i), MemAddr, {a_sel[31:2], 2'b00});
      if (wr_sel) check($sformatf("vec%0d_wdata", i), MemWData, d_sel);
      tick(); settle();
      check($sformatf("vec%0d_cpuack", i), CpuAck, !vecs[i].exp_ld);
      check($sformatf("vec%0d_ldack", i), LdAck, vecs[i].exp_ld);
      check($sformatf("vec%0d_rddata", i), RdData, vecs[i].exp_rdata);
      tick();
      drop_all();
    end

    // Both requesters held: grants alternate CPU, loader, CPU, loader.
    do_reset();
    CpuReq = 1; CpuWr = 0; CpuAddr = 32'h100;
    LdReq = 1; LdWr = 0; LdAddr = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      settle();
      check($sformatf("rr_c%0d_cpuack", c), CpuAck, (c % 6) == 3);
      check($sformatf("rr_c%0d_ldack", c), LdAck, (c % 6) == 0);
      tick();
    end

    // Lock burst: loader keeps the port until LdLock falls, then the CPU wins.
    do_reset();
    CpuReq = 1; CpuWr = 0; CpuAddr = 32'h100;
    LdReq = 1; LdWr = 0; LdAddr = 32'h40; LdLock = 1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 10) LdLock = 0;
      settle();
      check($sformatf("lock_c%0d_cpuack", c), CpuAck, c == 12);
      check($sformatf("lock_c%0d_ldack", c), LdAck, (c == 3) || (c == 6) || (c == 9));
      tick();
    end

    // A request dropped after being latched still completes.
    do_reset();
    LdReq = 1; LdWr = 0; LdAddr = 32'h40;
    settle();
    tick();
    LdReq = 0;
    settle();
    check("drop_memrd", MemRd, 1);
    tick(); settle();
    check("drop_ldack", LdAck, 1);
    check("drop_rddata", RdData, 32'h12345678);
    tick();

    // Reset during ACC abandons the transfer.
    CpuReq = 1; CpuWr = 1; CpuAddr = 32'h80; CpuWData = 32'hFFFF0000;
    settle();
    tick(); settle();
    check("rstacc_memwr_before", MemWr, 1);
    rst = 1;
    tick(); settle();
    check("rstacc_memrd", MemRd, 0);
    check("rstacc_memwr", MemWr, 0);
    check("rstacc_cpuack", CpuAck, 0);
    check("rstacc_stallcnt", StallCnt, 0);
    rst = 0;
    CpuReq = 0;
    for (int c = 0; c < 3; c++) begin
      tick(); settle();
      check("rstacc_noack_cpu", CpuAck, 0);
      check("rstacc_noack_ld", LdAck, 0);
      check("rstacc_nostrobe", MemWr | MemRd, 0);
    end
    tick();
    CpuReq = 1; CpuWr = 0; CpuAddr = 32'h100;
    settle();
    tick(); tick(); settle();
    check("rstacc_after_ack", CpuAck, 1);
    check("rstacc_after_data", RdData, 32'hDEADBEEF);
    tick();
    drop_all();

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < 32; i++) mmem[i] = 32'h0;
    next_sample = 0; ack_cyc = -1; ack_ld = 0;
    model_last = 1; model_rd = 32'h0; exp_rd = 32'h0;
    cpu_pend = 0; ld_pend = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!cpu_pend && ($urandom_range(0, 2) == 0)) begin
        cpu_pend = 1; CpuWr = 1'($urandom_range(0, 1));
        CpuAddr = 32'h200 + 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
        CpuWData = $urandom;
      end
      if (!ld_pend && ($urandom_range(0, 2) == 0)) begin
        ld_pend = 1; LdWr = 1'($urandom_range(0, 1));
        LdAddr = 32'h200 + 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
        LdWData = $urandom;
      end
      CpuReq = cpu_pend;
      LdReq  = ld_pend;
      LdLock = 1'($urandom_range(0, 1));
      if (k == next_sample) begin
        if (cpu_pend || ld_pend) begin
          if (cpu_pend && ld_pend) w = (LdLock && model_last) ? 1'b1 : !model_last;
          else                     w = ld_pend;
          wr_sel = w ? LdWr : CpuWr;
          a_sel  = w ? LdAddr : CpuAddr;
          d_sel  = w ? LdWData : CpuWData;
          if (wr_sel) begin
            mmem[(a_sel - 32'h200) >> 2] = d_sel;
          end else begin
            model_rd = mmem[(a_sel - 32'h200) >> 2];
          end
          exp_rd = model_rd;
          ack_cyc = k + 2; ack_ld = w; model_last = w;
          next_sample = k + 3;
        end else begin
          next_sample = k + 1;
        end
      end
      hit = (k == ack_cyc);
      settle();
      check("rnd_cpuack", CpuAck, hit && !ack_ld);
      check("rnd_ldack", LdAck, hit && ack_ld);
      check("rnd_stall", CpuStall, cpu_pend && !(hit && !ack_ld));
      if (hit) begin
        check("rnd_rddata", RdData, exp_rd);
        if (ack_ld) ld_pend = 0;
        else        cpu_pend = 0;
      end
      tick();
    end
    drop_all();

    // Continuous CPU stall behind a locked loader drives StallCnt to saturation.
    do_reset();
    CpuReq = 1; CpuWr = 0; CpuAddr = 32'h100;
    LdReq = 1; LdWr = 0; LdAddr = 32'h40; LdLock = 1;
    exp_cnt = 16'h0;
    for (int i = 0; i < 65545; i++) begin
      if ((i % 16384) == 0 || i >= 65530) begin
        settle();
        check("sat_stallcnt", StallCnt, exp_cnt);
        check("sat_stall", CpuStall, 1);
      end
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      tick();
    end
    drop_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
